// File: rtl/radix2_olm_pkg.sv
// Shared types, digit encodings and helpers for the radix-2 online multiplier.
package radix2_olm_pkg;

    typedef logic [1:0] sd_digit_t;

    localparam sd_digit_t SD_POS  = 2'b01;
    localparam sd_digit_t SD_ZERO = 2'b00;
    localparam sd_digit_t SD_NEG  = 2'b11;
    localparam sd_digit_t SD_BAD  = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StFlush
    } olm_state_e;

    // The unused code 10 decodes to zero.
    function automatic logic signed [1:0] sd_to_int(input sd_digit_t d);
        case (d)
            SD_POS:  return 2'sb01;
            SD_NEG:  return 2'sb11;
            default: return 2'sb00;
        endcase
    endfunction

endpackage

// File: rtl/radix2_olm_sel.sv
// Radix-2 online digit selection on a residual estimate with 3 integer and 2 fraction bits.
module radix2_olm_sel
    import radix2_olm_pkg::*;
(
    input  logic signed [4:0] v_hat,
    output logic [1:0]        p
);

    // Estimate is in units of 1/4.
    localparam logic signed [4:0] HALF     = 5'sb00010;
    localparam logic signed [4:0] NEG_HALF = 5'sb11110;

    always_comb begin
        p = SD_ZERO;
        if (v_hat >= HALF) begin
            p = SD_POS;
        end else if (v_hat < NEG_HALF) begin
            p = SD_NEG;
        end
    end

endmodule

// File: rtl/radix2_online_mult.sv
// Radix-2 online (MSD-first) signed-digit multiplier with ready/valid digit streams.
// Define RADIX2_OLM_DIGCHK_EN to flag accepted illegal digits (10) on a sticky err output.
module radix2_online_mult
    import radix2_olm_pkg::*;
#(
    parameter int unsigned NO_OF_DIGITS = 8,
    parameter int unsigned DELTA        = 3,
    parameter int unsigned W_FRAC       = NO_OF_DIGITS + DELTA
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] x_j,
    input  logic [1:0] y_j,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] p_j,
    output logic       last,
    output logic       busy,
    output logic       err
);

    localparam int unsigned N     = NO_OF_DIGITS;
    localparam int unsigned XW    = N + 2;
    localparam int unsigned WW    = W_FRAC + 3;
    localparam int unsigned STEPS = N + DELTA;
    localparam int unsigned CW    = $clog2(STEPS + 1);
    localparam int unsigned HSH   = W_FRAC - N - DELTA;

    olm_state_e           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic signed [XW-1:0] x_q, x_d, y_q, y_d;
    logic signed [WW-1:0] w_q, w_d;
    logic [1:0]           p_q;
    logic                 last_q, out_valid_q;

    logic                 out_free, step, feed, emit;
    logic signed [1:0]    xv, yv;
    logic signed [XW-1:0] weight, x_new, y_new, xy_term, yx_term;
    logic signed [WW-1:0] h, v, w_sel;
    logic [1:0]           p_sel;

    function automatic logic signed [XW-1:0] sd_times(input logic signed [1:0]    d,
                                                      input logic signed [XW-1:0] a);
        if (d == 2'sb01) begin
            return a;
        end else if (d == 2'sb11) begin
            return -a;
        end
        return '0;
    endfunction

    always_comb begin
        out_free = !out_valid_q || out_ready;
        in_ready = 1'b0;
        step     = 1'b0;
        unique case (state_q)
            StLoad: begin
                in_ready = 1'b1;
                step     = in_valid;
            end
            StRun: begin
                in_ready = out_free;
                step     = in_valid && out_free;
            end
            StFlush: step = out_free;
            default: ;
        endcase
    end

    assign feed = step && (state_q != StFlush);
    assign emit = step && (cnt_q >= CW'(DELTA));

    // Step cnt consumes digit index cnt+1; X and Y are scaled by 2^N, w by 2^W_FRAC.
    always_comb begin
        int unsigned k;
        k      = 32'(cnt_q) + 32'd1;
        weight = '0;
        if (k <= N) begin
            weight = XW'(1) << (N - k);
        end
        xv      = feed ? sd_to_int(x_j) : 2'sb00;
        yv      = feed ? sd_to_int(y_j) : 2'sb00;
        x_new   = x_q + sd_times(xv, weight);
        y_new   = y_q + sd_times(yv, weight);
        xy_term = sd_times(xv, y_q);
        yx_term = sd_times(yv, x_new);
        // 2^-DELTA times a 2^N-scaled operand lands exactly on the 2^(N+DELTA) grid.
        h       = (WW'(xy_term) + WW'(yx_term)) <<< HSH;
        v       = (w_q <<< 1) + h;
        w_sel   = v - (WW'(sd_to_int(p_sel)) <<< W_FRAC);
    end

    radix2_olm_sel u_sel (
        .v_hat(v[WW-1 -: 5]),
        .p    (p_sel)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        w_d     = w_q;
        if (state_q == StIdle) begin
            if (start) begin
                state_d = StLoad;
                cnt_d   = '0;
                x_d     = '0;
                y_d     = '0;
                w_d     = '0;
            end
        end else if (step) begin
            cnt_d = cnt_q + CW'(1);
            x_d   = x_new;
            y_d   = y_new;
            w_d   = emit ? w_sel : v;
            unique case (state_q)
                StLoad:  if (cnt_q == CW'(DELTA - 1)) state_d = StRun;
                StRun:   if (cnt_q == CW'(N - 1)) state_d = StFlush;
                StFlush: begin
                    if (cnt_q == CW'(STEPS - 1)) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            w_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            w_q     <= w_d;
        end
    end

    // A new digit overrides a pending clear, so back-to-back digits never drop out_valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_q         <= SD_ZERO;
            last_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (emit) begin
            p_q         <= p_sel;
            last_q      <= (cnt_q == CW'(STEPS - 1));
            out_valid_q <= 1'b1;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

`ifdef RADIX2_OLM_DIGCHK_EN
    logic err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if ((state_q == StIdle) && start) begin
            err_q <= 1'b0;
        end else if (feed && ((x_j == SD_BAD) || (y_j == SD_BAD))) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign busy      = (state_q != StIdle);
    assign p_j       = p_q;
    assign last      = last_q;
    assign out_valid = out_valid_q;

endmodule
